modulo_unwrap_recon_n: RTL and testbench
========================================

Name: modulo_unwrap_recon_n

Overview:
- Top-level reconstruction core for a self-reset (modulo) ADC front end.
- Each 12-bit ADC code is a signal folded into [-LAMBDA, LAMBDA).
- The core recovers the unfolded sample with an order-n difference, re-fold and n-fold integration scheme (n = 1..3, selectable at run time).
- It sits between the ADC capture logic and the DAC driver, is fully pipelined, and accepts one sample per start pulse.

Parameters:
- WIDTH, 24: internal signed fixed-point datapath width.
- LAMBDA, 24'h00C000: fold threshold, Q(WIDTH-FRACTIONAL_BITS).FRACTIONAL_BITS. Default is 0.75.
- FRACTIONAL_BITS, 16: number of fractional bits in the internal format.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Clears all state.
- clk_en  in  1  clock enable. When low, all registers hold and valid_out is forced to 0.
- start  in  1  one-cycle strobe; a new sample is present on adc_in.
- n  in  2  difference/integration order, sampled together with start.
- adc_in  in  12  unsigned ADC code.
- valid_out  out  1  one-cycle pulse; dac_out holds a new result.
- dac_out  out  32  signed reconstructed sample, Q.FRACTIONAL_BITS, sign-extended from WIDTH.

Behaviour:
- Reset (reset=0, asynchronous): history, accumulators and pipeline cleared; valid_out=0; dac_out=0; primed flag=0.
- Sample acceptance: on a rising edge with clk_en=1 and start=1, adc_in and n are latched. start may be asserted every enabled cycle, giving a throughput of 1 sample/cycle.
- Stage 1, scale: y = ((adc_in - 2048) * 2*LAMBDA) >>> 12, arithmetic shift, held in WIDTH bits.
  - code 0 -> -LAMBDA (-49152).
  - code 1000 -> -25152.
  - code 4095 -> 49128.
- Stage 2, difference: d = order-n backward difference of y, using a 3-deep history y[k-1..k-3].
  - n=1: y0-y1.
  - n=2: y0-2y1+y2.
  - n=3: y0-3y1+3y2-y3.
  - History shifts once per accepted sample.
- Stage 3, fold: f = ((d + LAMBDA) mod 2*LAMBDA) - LAMBDA, result in [-LAMBDA, LAMBDA).
  - Since |d| < 2^n * 2*LAMBDA, the fold is a fixed chain of conditional add/subtract of 2*LAMBDA*2^k for k=3..0, followed by a final range correction.
  - d = +LAMBDA folds to -LAMBDA.
- Stage 4, integrate: acc1 += f; acc2 += acc1 (n>=2); acc3 += acc2 (n>=3). Output is acc_n.
  - Accumulators are WIDTH bits and wrap in two's complement; no saturation.
- Priming: the first accepted sample after reset (primed=0) behaves as follows.
  - All history registers load y0.
  - acc_n loads y0 and lower accumulators load 0.
  - Output is y0; primed is then set to 1.
  - Changing n mid-stream without a reset is allowed; results are undefined until n+1 further samples.
- n=0: bypass; output = y, accumulators untouched.
- Latency: valid_out pulses, and dac_out updates, on the 4th enabled rising edge after the edge that sampled start. dac_out holds its value between pulses.
- clk_en=0 mid-pipeline: the pipeline freezes and resumes unchanged when clk_en returns high.
- start with clk_en=0: ignored.

Decomposition:
- Package recon_pkg: fixed-point constants (ADC_BITS=12, ADC_MID=2048), an order-type typedef for n, and the Q-format width localparams.
- Sub-module modulo_fold (parameters WIDTH, LAMBDA): combinational fold function wrapped with one pipeline register.
- Difference, history and integrator logic stay in the top module.

Test Plan:
- Reset with clk_en=1 and no start -> valid_out=0, dac_out=0. Asserting reset mid-pipeline -> no valid_out pulse for in-flight samples.
- n=2, one start per 200 cycles, codes 0, 0, 1000, 0, 1000, 1000, 0, 0 -> dac_out = -49152, -49152, -25152, -49152, -25152, -25152, -49152, -49152. Each valid_out is 4 cycles after its start.
- n=1, codes 4095 then 0 -> dac_out 49128 then 49152, i.e. the unwrapped value exceeds LAMBDA (d=-98280 folds to +24).
- n=3, codes 2048 (primes to 0), then ramp codes 2048, 2148, 2248 -> dac_out 0, 0, 2400, 4800.
- Back-to-back starts on consecutive cycles (n=2) -> valid_out high on consecutive cycles with results identical to the spaced-out case. Dropping clk_en for 5 cycles mid-stream -> results unchanged, only delayed.
- n=0 with code 1000 -> dac_out = -25152 after 4 cycles.

Source files
------------

// File: rtl/modulo_unwrap_recon_n_pkg.sv
// Shared constants and types for the modulo-ADC reconstruction core.
// Covers the ADC code format, the internal Q format and the order encoding.
package recon_pkg;

  localparam int ADC_BITS = 12;
  localparam int ADC_MID  = 2048;
  localparam int DAC_BITS = 32;
  localparam int Q_WIDTH  = 24;
  localparam int Q_FRAC   = 16;
  localparam int Q_INT    = Q_WIDTH - Q_FRAC;

  typedef enum logic [1:0] {
    ORD_BYPASS = 2'd0,
    ORD_1      = 2'd1,
    ORD_2      = 2'd2,
    ORD_3      = 2'd3
  } order_e;

endpackage

// File: rtl/modulo_unwrap_recon_n_fold.sv
// Re-folds a difference into [-LAMBDA, LAMBDA) by a fixed add/subtract chain.
// One register stage; en=0 holds the output.
module modulo_fold #(
  parameter int               WIDTH  = 24,
  parameter logic [WIDTH-1:0] LAMBDA = 24'h00C000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] d_i,
  output logic signed [WIDTH-1:0] f_o
);

  localparam int FW = WIDTH + 2;
  localparam logic signed [FW-1:0] L_W   = FW'({2'b00, LAMBDA});
  localparam logic signed [FW-1:0] TWO_L = L_W <<< 1;

  logic signed [FW-1:0]    v;
  logic signed [FW-1:0]    step;
  logic signed [WIDTH-1:0] f_d;
  logic signed [WIDTH-1:0] f_q;

  // Each stage halves the residual range: |d| < 16*LAMBDA narrows to [-LAMBDA, LAMBDA).
  always_comb begin
    v    = FW'(d_i);
    step = '0;
    for (int k = 3; k >= 0; k--) begin
      step = TWO_L <<< k;
      if (v >= step - L_W) begin
        v = v - step;
      end else if (v < L_W - step) begin
        v = v + step;
      end
    end
    if (v >= L_W) begin
      v = v - TWO_L;
    end else if (v < -L_W) begin
      v = v + TWO_L;
    end
    f_d = WIDTH'(v);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_q <= '0;
    end else if (en_i) begin
      f_q <= f_d;
    end
  end

  assign f_o = f_q;

endmodule

// File: rtl/modulo_unwrap_recon_n.sv
// Modulo-ADC unfolding core: scale, order-n difference, re-fold, n-fold integration.
// Result 4 enabled edges after start; clk_en=0 freezes every stage and masks valid_out.
module modulo_unwrap_recon_n
  import recon_pkg::*;
#(
  parameter int               WIDTH           = Q_WIDTH,
  parameter logic [WIDTH-1:0] LAMBDA          = 24'h00C000,
  parameter int               FRACTIONAL_BITS = Q_FRAC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                start,
  input  logic [1:0]          n,
  input  logic [ADC_BITS-1:0] adc_in,
  output logic                valid_out,
  output logic [DAC_BITS-1:0] dac_out
);

  if (WIDTH > DAC_BITS || FRACTIONAL_BITS >= WIDTH) begin : g_bad_cfg
    $error("modulo_unwrap_recon_n: unsupported WIDTH/FRACTIONAL_BITS");
  end

  localparam int PW = ADC_BITS + WIDTH + 2;
  localparam logic signed [PW-1:0] TWO_LAMBDA_W = PW'({LAMBDA, 1'b0});

  // ---------------- input latch ----------------
  logic                s0_vld_q;
  logic [ADC_BITS-1:0] s0_code_q;
  order_e              s0_n_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_vld_q  <= 1'b0;
      s0_code_q <= '0;
      s0_n_q    <= ORD_BYPASS;
    end else if (clk_en) begin
      s0_vld_q <= start;
      if (start) begin
        s0_code_q <= adc_in;
        s0_n_q    <= order_e'(n);
      end
    end
  end

  // ---------------- scale ----------------
  logic signed [PW-1:0]    centered_w;
  logic signed [PW-1:0]    scaled_w;
  logic signed [WIDTH-1:0] y_d;
  logic                    s1_vld_q;
  logic signed [WIDTH-1:0] s1_y_q;
  order_e                  s1_n_q;

  always_comb begin
    centered_w = PW'($signed({1'b0, s0_code_q})) - PW'(ADC_MID);
    scaled_w   = centered_w * TWO_LAMBDA_W;
    y_d        = WIDTH'(scaled_w >>> ADC_BITS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q <= 1'b0;
      s1_y_q   <= '0;
      s1_n_q   <= ORD_BYPASS;
    end else if (clk_en) begin
      s1_vld_q <= s0_vld_q;
      if (s0_vld_q) begin
        s1_y_q <= y_d;
        s1_n_q <= s0_n_q;
      end
    end
  end

  // ---------------- difference + history ----------------
  logic signed [WIDTH-1:0] h1_q, h2_q, h3_q;
  logic                    primed_q;
  logic signed [WIDTH-1:0] d_d;
  logic                    s2_vld_q;
  logic signed [WIDTH-1:0] s2_d_q;
  logic signed [WIDTH-1:0] s2_y_q;
  order_e                  s2_n_q;
  logic                    s2_first_q;

  always_comb begin
    d_d = '0;
    case (s1_n_q)
      ORD_1:   d_d = s1_y_q - h1_q;
      ORD_2:   d_d = s1_y_q - (h1_q <<< 1) + h2_q;
      ORD_3:   d_d = s1_y_q - (h1_q <<< 1) - h1_q + (h2_q <<< 1) + h2_q - h3_q;
      default: d_d = '0;
    endcase
  end

  // The first sample after reset seeds the whole history so later differences start from it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1_q       <= '0;
      h2_q       <= '0;
      h3_q       <= '0;
      primed_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_d_q     <= '0;
      s2_y_q     <= '0;
      s2_n_q     <= ORD_BYPASS;
      s2_first_q <= 1'b0;
    end else if (clk_en) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_d_q     <= d_d;
        s2_y_q     <= s1_y_q;
        s2_n_q     <= s1_n_q;
        s2_first_q <= !primed_q;
        primed_q   <= 1'b1;
        h1_q       <= s1_y_q;
        h2_q       <= primed_q ? h1_q : s1_y_q;
        h3_q       <= primed_q ? h2_q : s1_y_q;
      end
    end
  end

  // ---------------- fold ----------------
  logic signed [WIDTH-1:0] s3_f;
  logic                    s3_vld_q;
  logic signed [WIDTH-1:0] s3_y_q;
  order_e                  s3_n_q;
  logic                    s3_first_q;

  modulo_fold #(
    .WIDTH  (WIDTH),
    .LAMBDA (LAMBDA)
  ) u_fold (
    .clk   (clk),
    .reset (reset),
    .en_i  (clk_en),
    .d_i   (s2_d_q),
    .f_o   (s3_f)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s3_vld_q   <= 1'b0;
      s3_y_q     <= '0;
      s3_n_q     <= ORD_BYPASS;
      s3_first_q <= 1'b0;
    end else if (clk_en) begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        s3_y_q     <= s2_y_q;
        s3_n_q     <= s2_n_q;
        s3_first_q <= s2_first_q;
      end
    end
  end

  // ---------------- integrate ----------------
  logic signed [WIDTH-1:0] acc1_q, acc2_q, acc3_q;
  logic signed [WIDTH-1:0] acc1_sum, acc2_sum, acc3_sum;
  logic signed [WIDTH-1:0] acc1_d, acc2_d, acc3_d;
  logic signed [WIDTH-1:0] dac_d, dac_q;
  logic                    valid_q;

  // Cascade uses freshly updated lower accumulators, so acc_n tracks y after priming.
  always_comb begin
    acc1_sum = acc1_q + s3_f;
    acc2_sum = acc2_q + acc1_sum;
    acc3_sum = acc3_q + acc2_sum;
    acc1_d   = acc1_q;
    acc2_d   = acc2_q;
    acc3_d   = acc3_q;
    dac_d    = s3_y_q;
    case (s3_n_q)
      ORD_1: begin
        if (s3_first_q) begin
          acc1_d = s3_y_q;
        end else begin
          acc1_d = acc1_sum;
          dac_d  = acc1_sum;
        end
      end
      ORD_2: begin
        if (s3_first_q) begin
          acc1_d = '0;
          acc2_d = s3_y_q;
        end else begin
          acc1_d = acc1_sum;
          acc2_d = acc2_sum;
          dac_d  = acc2_sum;
        end
      end
      ORD_3: begin
        if (s3_first_q) begin
          acc1_d = '0;
          acc2_d = '0;
          acc3_d = s3_y_q;
        end else begin
          acc1_d = acc1_sum;
          acc2_d = acc2_sum;
          acc3_d = acc3_sum;
          dac_d  = acc3_sum;
        end
      end
      default: begin
        dac_d = s3_y_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc1_q  <= '0;
      acc2_q  <= '0;
      acc3_q  <= '0;
      dac_q   <= '0;
      valid_q <= 1'b0;
    end else if (clk_en) begin
      valid_q <= s3_vld_q;
      if (s3_vld_q) begin
        acc1_q <= acc1_d;
        acc2_q <= acc2_d;
        acc3_q <= acc3_d;
        dac_q  <= dac_d;
      end
    end
  end

  assign valid_out = valid_q & clk_en;
  assign dac_out   = DAC_BITS'(dac_q);

endmodule

// File: tb/tb_modulo_unwrap_recon_n.sv
// Directed bench for modulo_unwrap_recon_n: reset, each order, back-to-back and clk_en stall.
module tb_modulo_unwrap_recon_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [1:0]  n;
  logic [11:0] adc_in;
  logic        valid_out;
  logic [31:0] dac_out;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] n2_codes [8] = '{12'd0, 12'd0, 12'd1000, 12'd0, 12'd1000, 12'd1000, 12'd0, 12'd0};
  int          n2_exp   [8] = '{-49152, -49152, -25152, -49152, -25152, -25152, -49152, -49152};

  modulo_unwrap_recon_n dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .n         (n),
    .adc_in    (adc_in),
    .valid_out (valid_out),
    .dac_out   (dac_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    n      = 2'd0;
    adc_in = 12'd0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  // One start, then 200 edges of observation; reports first pulse edge and pulse count.
  task automatic spaced_sample(input logic [11:0] code, input logic [1:0] ord,
                               output logic [31:0] got, output int lat, output int pulses);
    adc_in = code;
    n      = ord;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    got    = 32'hDEAD_BEEF;
    lat    = -1;
    pulses = 0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (valid_out === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = e;
          got = dac_out;
        end
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    do_reset();
    n_vec++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: valid_out=%0b expected 0", valid_out);
    end
    n_vec++;
    if (dac_out !== 32'd0) begin
      n_err++;
      $display("FAIL reset_dac: dac_out=%0d expected 0", $signed(dac_out));
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_out === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL reset_idle_pulses: saw %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] got;
    int lat, pulses;
    do_reset();
    spaced_sample(12'd1000, 2'd0, got, lat, pulses);
    n_vec++;
    if (got !== 32'hFFFF_9DC0) begin
      n_err++;
      $display("FAIL bypass_dac: dac_out=%0d expected -25152", $signed(got));
    end
    n_vec++;
    if (lat !== 4 || pulses !== 1) begin
      n_err++;
      $display("FAIL bypass_latency: latency=%0d pulses=%0d expected 4 and 1", lat, pulses);
    end
  endtask

  // Runs right after test_bypass, so dac_out starts non-zero.
  task automatic test_reset_midpipe();
    int pulses;
    n      = 2'd0;
    adc_in = 12'd0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if (dac_out !== 32'd0 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL midpipe_reset_clear: dac_out=%0d valid_out=%0b expected 0 and 0",
               $signed(dac_out), valid_out);
    end
    tick();
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_out === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL midpipe_no_pulse: saw %0d pulses expected 0", pulses);
    end
    n_vec++;
    if (dac_out !== 32'd0) begin
      n_err++;
      $display("FAIL midpipe_dac_hold: dac_out=%0d expected 0", $signed(dac_out));
    end
  endtask

  task automatic test_n2_spaced();
    logic [31:0] got;
    int lat, pulses;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      spaced_sample(n2_codes[i], 2'd2, got, lat, pulses);
      n_vec++;
      if (got !== n2_exp[i]) begin
        n_err++;
        $display("FAIL n2_spaced_dac[%0d]: dac_out=%0d expected %0d", i, $signed(got), n2_exp[i]);
      end
      n_vec++;
      if (lat !== 4 || pulses !== 1) begin
        n_err++;
        $display("FAIL n2_spaced_latency[%0d]: latency=%0d pulses=%0d expected 4 and 1",
                 i, lat, pulses);
      end
    end
  endtask

  task automatic test_n1_overflow();
    logic [31:0] got;
    int lat, pulses;
    do_reset();
    spaced_sample(12'd4095, 2'd1, got, lat, pulses);
    n_vec++;
    if (got !== 32'd49128 || lat !== 4) begin
      n_err++;
      $display("FAIL n1_prime: dac_out=%0d latency=%0d expected 49128 at 4", $signed(got), lat);
    end
    spaced_sample(12'd0, 2'd1, got, lat, pulses);
    n_vec++;
    if (got !== 32'd49152 || lat !== 4) begin
      n_err++;
      $display("FAIL n1_unwrap: dac_out=%0d latency=%0d expected 49152 at 4", $signed(got), lat);
    end
  endtask

  task automatic test_n3_ramp();
    logic [11:0] codes [4];
    int          expv  [4];
    logic [31:0] got;
    int lat, pulses;
    codes = '{12'd2048, 12'd2048, 12'd2148, 12'd2248};
    expv  = '{0, 0, 2400, 4800};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      spaced_sample(codes[i], 2'd3, got, lat, pulses);
      n_vec++;
      if (got !== expv[i]) begin
        n_err++;
        $display("FAIL n3_ramp_dac[%0d]: dac_out=%0d expected %0d", i, $signed(got), expv[i]);
      end
      n_vec++;
      if (lat !== 4 || pulses !== 1) begin
        n_err++;
        $display("FAIL n3_ramp_latency[%0d]: latency=%0d pulses=%0d expected 4 and 1",
                 i, lat, pulses);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [8];
    int          at  [8];
    int          idx;
    do_reset();
    n   = 2'd2;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      got[i] = 32'hDEAD_BEEF;
      at[i]  = -1;
    end
    for (int c = 0; c < 40; c++) begin
      if (c < 8) begin
        start  = 1'b1;
        adc_in = n2_codes[c];
      end else begin
        start = 1'b0;
      end
      #1;
      if (valid_out === 1'b1) begin
        if (idx < 8) begin
          got[idx] = dac_out;
          at[idx]  = c;
        end
        idx++;
      end
      tick();
    end
    n_vec++;
    if (idx !== 8) begin
      n_err++;
      $display("FAIL b2b_count: saw %0d pulses expected 8", idx);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (got[i] !== n2_exp[i]) begin
        n_err++;
        $display("FAIL b2b_dac[%0d]: dac_out=%0d expected %0d", i, $signed(got[i]), n2_exp[i]);
      end
      n_vec++;
      if (at[i] !== i + 5) begin
        n_err++;
        $display("FAIL b2b_timing[%0d]: pulse in cycle %0d expected %0d", i, at[i], i + 5);
      end
    end
  endtask

  // clk_en low for 5 cycles while start stays asserted; those starts must be ignored.
  task automatic test_clk_en_stall();
    logic [31:0] got [8];
    int          at  [8];
    int          idx, si;
    do_reset();
    n   = 2'd2;
    idx = 0;
    si  = 0;
    for (int i = 0; i < 8; i++) begin
      got[i] = 32'hDEAD_BEEF;
      at[i]  = -1;
    end
    for (int c = 0; c < 40; c++) begin
      clk_en = !(c >= 5 && c < 10);
      if (si < 8) begin
        start  = 1'b1;
        adc_in = n2_codes[si];
      end else begin
        start = 1'b0;
      end
      #1;
      if (valid_out === 1'b1) begin
        if (idx < 8) begin
          got[idx] = dac_out;
          at[idx]  = c;
        end
        idx++;
      end
      tick();
      if (clk_en && start) si++;
    end
    clk_en = 1'b1;
    n_vec++;
    if (idx !== 8) begin
      n_err++;
      $display("FAIL stall_count: saw %0d pulses expected 8", idx);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (got[i] !== n2_exp[i]) begin
        n_err++;
        $display("FAIL stall_dac[%0d]: dac_out=%0d expected %0d", i, $signed(got[i]), n2_exp[i]);
      end
      n_vec++;
      if (at[i] !== i + 10) begin
        n_err++;
        $display("FAIL stall_timing[%0d]: pulse in cycle %0d expected %0d", i, at[i], i + 10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_reset_midpipe();
    test_n2_spaced();
    test_n1_overflow();
    test_n3_ramp();
    test_back_to_back();
    test_clk_en_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
